// File: rtl/y86_trace_checker.sv
// Y86 commit-trace checker: compares committed PC/register state against a loaded golden trace.
// Optional simulation print-out enabled by defining Y86_TRACE_CHECK_DISPLAY_EN.
module y86_trace_checker #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [287:0]  load_data,
  input  logic          start,
  input  logic [AW:0]   trace_len,
  input  logic          commit_valid,
  input  logic [287:0]  commit_state,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [AW:0]   match_count,
  output logic [AW-1:0] err_index,
  output logic [3:0]    err_field,
  output logic [31:0]   err_expected,
  output logic [31:0]   err_actual
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_PASS = 2'd2,
    S_FAIL = 2'd3
  } state_t;

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  // Returns {found, field}; scanning from edi down to PC leaves the lowest-numbered difference.
  function automatic logic [4:0] first_diff(input logic [287:0] gold, input logic [287:0] act);
    logic [4:0] r;
    r = 5'd0;
    for (int f = 8; f >= 0; f--) begin
      if (gold[f*32 +: 32] != act[f*32 +: 32]) begin
        r = {1'b1, 4'(f)};
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  logic [287:0]  mem_q [DEPTH];
  state_t        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW:0]   len_q, len_d;
  logic [AW:0]   match_q, match_d;
  logic [AW-1:0] err_index_q, err_index_d;
  logic [3:0]    err_field_q, err_field_d;
  logic [31:0]   err_exp_q, err_exp_d;
  logic [31:0]   err_act_q, err_act_d;

  logic [287:0]  golden_s;
  logic [4:0]    diff_s;
  logic [AW:0]   len_clamped_s;
  logic          last_s;

  assign golden_s      = mem_q[idx_q];
  assign diff_s        = first_diff(golden_s, commit_state);
  assign len_clamped_s = (trace_len > DEPTH_W) ? DEPTH_W : trace_len;
  assign last_s        = ({1'b0, idx_q} == (len_q - (AW+1)'(1)));

  // Golden memory: written only while idle; contents survive reset.
  always_ff @(posedge clk) begin
    if (!reset && load_en && !start && (state_q == S_IDLE)) begin
      mem_q[load_addr] <= load_data;
    end
  end

  // Next-state and result-register logic; start overrides everything else.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    len_d       = len_q;
    match_d     = match_q;
    err_index_d = err_index_q;
    err_field_d = err_field_q;
    err_exp_d   = err_exp_q;
    err_act_d   = err_act_q;
    if (start) begin
      state_d     = (len_clamped_s == (AW+1)'(0)) ? S_PASS : S_RUN;
      len_d       = len_clamped_s;
      idx_d       = AW'(0);
      match_d     = (AW+1)'(0);
      err_index_d = AW'(0);
      err_field_d = 4'd0;
      err_exp_d   = 32'd0;
      err_act_d   = 32'd0;
    end else begin
      case (state_q)
        S_RUN: begin
          if (commit_valid) begin
            if (diff_s[4]) begin
              state_d     = S_FAIL;
              err_index_d = idx_q;
              err_field_d = diff_s[3:0];
              err_exp_d   = golden_s[int'(diff_s[3:0])*32 +: 32];
              err_act_d   = commit_state[int'(diff_s[3:0])*32 +: 32];
            end else begin
              match_d = match_q + (AW+1)'(1);
              // Hold idx on the final entry so it never wraps past DEPTH-1.
              if (last_s) begin
                state_d = S_PASS;
              end else begin
                idx_d = idx_q + AW'(1);
              end
            end
          end else begin
            state_d = S_RUN;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  // State and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= AW'(0);
      len_q       <= (AW+1)'(0);
      match_q     <= (AW+1)'(0);
      err_index_q <= AW'(0);
      err_field_q <= 4'd0;
      err_exp_q   <= 32'd0;
      err_act_q   <= 32'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      match_q     <= match_d;
      err_index_q <= err_index_d;
      err_field_q <= err_field_d;
      err_exp_q   <= err_exp_d;
      err_act_q   <= err_act_d;
    end
  end

  assign busy         = (state_q == S_RUN);
  assign done         = (state_q == S_PASS) || (state_q == S_FAIL);
  assign pass         = (state_q == S_PASS);
  assign match_count  = match_q;
  assign err_index    = err_index_q;
  assign err_field    = err_field_q;
  assign err_expected = err_exp_q;
  assign err_actual   = err_act_q;

`ifdef Y86_TRACE_CHECK_DISPLAY_EN
  function automatic string field_name(input logic [3:0] f);
    case (f)
      4'd0:    return "pc";
      4'd1:    return "eax";
      4'd2:    return "ecx";
      4'd3:    return "edx";
      4'd4:    return "ebx";
      4'd5:    return "esp";
      4'd6:    return "ebp";
      4'd7:    return "esi";
      4'd8:    return "edi";
      default: return "???";
    endcase
  endfunction

  // Trace print-out in the same column order as the simulation trace.
  always_ff @(posedge clk) begin
    if (!reset && !start && (state_q == S_RUN) && commit_valid) begin
      $display("%0d %08h %08h %08h %08h %08h %08h %08h %08h %08h", idx_q,
               commit_state[31:0], commit_state[63:32], commit_state[95:64],
               commit_state[127:96], commit_state[159:128], commit_state[191:160],
               commit_state[223:192], commit_state[255:224], commit_state[287:256]);
    end
    if (!reset && (state_d == S_FAIL) && (state_q != S_FAIL)) begin
      $display("trace check mismatch at %0d field %s expected %08h actual %08h",
               err_index_d, field_name(err_field_d), err_exp_d, err_act_d);
    end
    if (!reset && (state_d == S_PASS) && (state_q != S_PASS)) begin
      $display("trace check complete: %0d entries matched", match_d);
    end
  end
`endif

endmodule
